// File: rtl/bp_cfg_loader_pkg.sv
// Shared types for the boot-time configuration loader and its config-bus endpoints.
package bp_cfg_loader_pkg;

  typedef enum logic [2:0] {
    e_idle,
    e_fetch,
    e_send,
    e_unfreeze,
    e_done,
    e_error
  } bp_cfg_loader_state_e;

  localparam int bp_cfg_invalid_id_gp = 0;

  // Widest supported config-bus write; narrower instances zero-extend into it.
  typedef logic [7:0]  bus_core_t;
  typedef logic [15:0] bus_addr_t;
  typedef logic [63:0] bus_data_t;

  typedef struct packed {
    bus_core_t core;
    bus_addr_t addr;
    bus_data_t data;
  } bp_cfg_bus_s;

endpackage

// File: rtl/bp_cfg_loader_if.sv
// Valid/ready config-bus write channel from the loader to the per-tile endpoints.
interface bp_cfg_loader_if #(
  parameter int core_width_p = 1,
  parameter int addr_width_p = 8,
  parameter int data_width_p = 64
);
  logic                    v;
  logic                    ready;
  logic [core_width_p-1:0] core;
  logic [addr_width_p-1:0] addr;
  logic [data_width_p-1:0] data;

  modport master (output v, core, addr, data, input ready);
  modport slave  (input v, core, addr, data, output ready);
endinterface

// File: rtl/bp_cfg_loader.sv
// Streams one ROM-selected configuration to every core, then releases the cores from freeze in order.
module bp_cfg_loader
  import bp_cfg_loader_pkg::*;
#(
  parameter int num_cores_p      = 1,
  parameter int cfg_words_p      = 8,
  parameter int num_cfgs_p       = 9,
  parameter int cfg_id_width_p   = 7,
  parameter int cfg_addr_width_p = 8,
  parameter int cfg_data_width_p = 64,
  parameter logic [cfg_addr_width_p-1:0] freeze_addr_p = 8'hFF,
  localparam int core_width_lp = (num_cores_p > 1) ? $clog2(num_cores_p) : 1,
  localparam int word_width_lp = (cfg_words_p > 1) ? $clog2(cfg_words_p) : 1
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic                        start_i,
  input  logic [cfg_id_width_p-1:0]   cfg_sel_i,
  output logic [cfg_id_width_p-1:0]   rom_cfg_o,
  output logic [word_width_lp-1:0]    rom_addr_o,
  input  logic [cfg_data_width_p-1:0] rom_data_i,
  bp_cfg_loader_if.master             cfg,
  output logic [num_cores_p-1:0]      freeze_o,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        err_o
);
  // state     | meaning
  // e_idle    | waiting for the first start after reset
  // e_fetch   | ROM addressed with word_cnt; capture word into the bus registers
  // e_send    | config word offered on the bus, held until accepted
  // e_unfreeze| freeze-register clear offered to core core_cnt
  // e_done    | every core loaded and released
  // e_error   | last start named an invalid config

  localparam logic [core_width_lp-1:0] last_core_lp = core_width_lp'(num_cores_p - 1);
  localparam logic [word_width_lp-1:0] last_word_lp = word_width_lp'(cfg_words_p - 1);

  bp_cfg_loader_state_e          state_r;
  logic [core_width_lp-1:0]      core_cnt_r;
  logic [word_width_lp-1:0]      word_cnt_r;
  logic                          v_r;
  logic [core_width_lp-1:0]      core_r;
  logic [cfg_addr_width_p-1:0]   addr_r;
  logic [cfg_data_width_p-1:0]   data_r;
  logic [cfg_id_width_p-1:0]     rom_cfg_r;
  logic [num_cores_p-1:0]        freeze_r;
  logic                          busy_r;
  logic                          done_r;
  logic                          err_r;
  logic                          sel_ok;
  logic                          handshake;

  assign sel_ok    = (int'(cfg_sel_i) != bp_cfg_invalid_id_gp) && (int'(cfg_sel_i) < num_cfgs_p);
  assign handshake = v_r & cfg.ready;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r    <= e_idle;
      core_cnt_r <= '0;
      word_cnt_r <= '0;
      v_r        <= 1'b0;
      core_r     <= '0;
      addr_r     <= '0;
      data_r     <= '0;
      rom_cfg_r  <= '0;
      freeze_r   <= '1;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      unique case (state_r)
        e_idle, e_done, e_error: begin
          if (start_i) begin
            rom_cfg_r <= cfg_sel_i;
            done_r    <= 1'b0;
            if (!sel_ok) begin
              err_r   <= 1'b1;
              state_r <= e_error;
            end else begin
              err_r      <= 1'b0;
              core_cnt_r <= '0;
              word_cnt_r <= '0;
              freeze_r   <= '1;
              busy_r     <= 1'b1;
              state_r    <= e_fetch;
            end
          end
        end
        e_fetch: begin
          core_r  <= core_cnt_r;
          addr_r  <= cfg_addr_width_p'(word_cnt_r);
          data_r  <= rom_data_i;
          v_r     <= 1'b1;
          state_r <= e_send;
        end
        e_send: begin
          if (handshake) begin
            if (word_cnt_r != last_word_lp) begin
              word_cnt_r <= word_cnt_r + word_width_lp'(1);
              v_r        <= 1'b0;
              state_r    <= e_fetch;
            end else if (core_cnt_r != last_core_lp) begin
              word_cnt_r <= '0;
              core_cnt_r <= core_cnt_r + core_width_lp'(1);
              v_r        <= 1'b0;
              state_r    <= e_fetch;
            end else begin
              // Valid stays high: the first freeze clear goes out on the very next cycle.
              core_cnt_r <= '0;
              core_r     <= '0;
              addr_r     <= freeze_addr_p;
              data_r     <= '0;
              state_r    <= e_unfreeze;
            end
          end
        end
        e_unfreeze: begin
          if (handshake) begin
            freeze_r <= freeze_r & ~(num_cores_p'(1) << core_cnt_r);
            if (core_cnt_r == last_core_lp) begin
              v_r     <= 1'b0;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
              state_r <= e_done;
            end else begin
              core_cnt_r <= core_cnt_r + core_width_lp'(1);
              core_r     <= core_cnt_r + core_width_lp'(1);
            end
          end
        end
        default: state_r <= e_idle;
      endcase
    end
  end

  assign rom_cfg_o  = rom_cfg_r;
  assign rom_addr_o = word_cnt_r;
  assign cfg.v      = v_r;
  assign cfg.core   = core_r;
  assign cfg.addr   = addr_r;
  assign cfg.data   = data_r;
  assign freeze_o   = freeze_r;
  assign busy_o     = busy_r;
  assign done_o     = done_r;
  assign err_o      = err_r;

endmodule

// File: tb/tb_bp_cfg_loader.sv
// Bench for bp_cfg_loader: one single-core instance for exact timing, one dual-core instance for ordering.
module tb_bp_cfg_loader;
  import bp_cfg_loader_pkg::*;

  logic        clk, rst_n;
  logic        start1, start2;
  logic [6:0]  sel1, sel2, rom_cfg1, rom_cfg2;
  logic [2:0]  rom_addr1, rom_addr2;
  logic [63:0] rom_data1, rom_data2;
  logic        freeze1;
  logic [1:0]  freeze2;
  logic        busy1, done1, err1, busy2, done2, err2;
  int          n_vec = 0;
  int          n_err = 0;

  bp_cfg_loader_if #(.core_width_p(1), .addr_width_p(8), .data_width_p(64)) bus1 ();
  bp_cfg_loader_if #(.core_width_p(1), .addr_width_p(8), .data_width_p(64)) bus2 ();

  bp_cfg_loader #(.num_cores_p(1)) dut1 (
    .clk_i(clk), .reset_n_i(rst_n), .start_i(start1), .cfg_sel_i(sel1),
    .rom_cfg_o(rom_cfg1), .rom_addr_o(rom_addr1), .rom_data_i(rom_data1), .cfg(bus1),
    .freeze_o(freeze1), .busy_o(busy1), .done_o(done1), .err_o(err1));

  bp_cfg_loader #(.num_cores_p(2)) dut2 (
    .clk_i(clk), .reset_n_i(rst_n), .start_i(start2), .cfg_sel_i(sel2),
    .rom_cfg_o(rom_cfg2), .rom_addr_o(rom_addr2), .rom_data_i(rom_data2), .cfg(bus2),
    .freeze_o(freeze2), .busy_o(busy2), .done_o(done2), .err_o(err2));

  // Stand-in configuration ROM: a distinct word for every {id, index}.
  function automatic logic [63:0] rom_word(input logic [6:0] id, input logic [2:0] idx);
    return {id, 1'b0, 5'(idx), 3'b101, 48'h0} ^ (64'(id) * 64'h9E37_79B9_7F4A_7C15)
           ^ (64'(idx) * 64'h0123_4567_89AB_CDEF);
  endfunction

  assign rom_data1 = rom_word(rom_cfg1, rom_addr1);
  assign rom_data2 = rom_word(rom_cfg2, rom_addr2);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++; if (bus1.v !== 1'b0 || bus2.v !== 1'b0) begin n_err++; $display("FAIL reset_v: got %b/%b expected 0/0", bus1.v, bus2.v); end
    n_vec++; if ({bus1.core, bus1.addr, bus1.data} !== 73'h0) begin n_err++; $display("FAIL reset_bus: got %h expected 0", {bus1.core, bus1.addr, bus1.data}); end
    n_vec++; if ({rom_cfg1, rom_addr1} !== 10'h0) begin n_err++; $display("FAIL reset_rom: got %h expected 0", {rom_cfg1, rom_addr1}); end
    n_vec++; if (freeze1 !== 1'b1 || freeze2 !== 2'b11) begin n_err++; $display("FAIL reset_freeze: got %b/%b expected 1/11", freeze1, freeze2); end
    n_vec++; if ({busy1, done1, err1, busy2, done2, err2} !== 6'b0) begin n_err++; $display("FAIL reset_status: got %b expected 000000", {busy1, done1, err1, busy2, done2, err2}); end
    #2 rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      n_vec++; if (bus1.v !== 1'b0 || busy1 !== 1'b0) begin n_err++; $display("FAIL idle_quiet: got v=%b busy=%b expected 0/0", bus1.v, busy1); end
    end
  endtask

  // Cycle-exact single-core load; the start is in cycle 0, cycle k is observed at the k-th negedge after it.
  task automatic test_single(input logic [6:0] sel, input int stall_word, input int stall_len);
    int send_at[8];
    int unf, fin;
    logic exp_v;
    logic [7:0] exp_addr;
    logic [63:0] exp_data;
    for (int w = 0; w < 8; w++) send_at[w] = 2 + 2 * w + ((w > stall_word) ? stall_len : 0);
    unf = 17 + stall_len;
    fin = unf + 1;
    @(negedge clk);
    start1 = 1'b1; sel1 = sel; bus1.ready = 1'b1;
    for (int k = 1; k <= fin; k++) begin
      @(negedge clk);
      start1 = 1'b0;
      bus1.ready = !(k >= send_at[stall_word] && k < send_at[stall_word] + stall_len);
      exp_v = 1'b0; exp_addr = 8'h0; exp_data = 64'h0;
      for (int w = 0; w < 8; w++)
        if (k >= send_at[w] && k <= send_at[w] + ((w == stall_word) ? stall_len : 0)) begin
          exp_v = 1'b1; exp_addr = 8'(w); exp_data = rom_word(sel, 3'(w));
        end
      if (k == unf) begin exp_v = 1'b1; exp_addr = 8'hFF; exp_data = 64'h0; end
      n_vec++; if (bus1.v !== exp_v) begin n_err++; $display("FAIL single_v c%0d: got %b expected %b", k, bus1.v, exp_v); end
      if (exp_v) begin
        n_vec++;
        if (bus1.addr !== exp_addr || bus1.data !== exp_data || bus1.core !== 1'b0) begin
          n_err++; $display("FAIL single_word c%0d: got %h/%h/%b expected %h/%h/0", k, bus1.addr, bus1.data, bus1.core, exp_addr, exp_data);
        end
      end
      n_vec++;
      if ({busy1, freeze1, done1} !== {k < fin, k < fin, k == fin}) begin
        n_err++; $display("FAIL single_status c%0d: got %b expected %b", k, {busy1, freeze1, done1}, {k < fin, k < fin, k == fin});
      end
    end
    n_vec++; if (rom_cfg1 !== sel) begin n_err++; $display("FAIL single_rom_cfg: got %0d expected %0d", rom_cfg1, sel); end
  endtask

  // Dual-core load against an ordered scoreboard; optional ignored start at cycle mid_start.
  task automatic test_load(input logic [6:0] sel, input int mid_start, input int stall_pct);
    bp_cfg_bus_s q[$];
    bp_cfg_bus_s got;
    logic [1:0] exp_freeze;
    logic prev_stall;
    logic fin;
    int cyc;
    for (int c = 0; c < 2; c++)
      for (int w = 0; w < 8; w++) q.push_back('{core: bus_core_t'(c), addr: bus_addr_t'(w), data: rom_word(sel, 3'(w))});
    for (int c = 0; c < 2; c++) q.push_back('{core: bus_core_t'(c), addr: 16'h00FF, data: 64'h0});
    exp_freeze = 2'b11; prev_stall = 1'b0; fin = 1'b0; cyc = 0;
    @(negedge clk);
    start2 = 1'b1; sel2 = sel;
    while (!fin && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      start2 = (cyc == mid_start);
      sel2 = (cyc == mid_start) ? 7'((sel % 8) + 1) : sel;
      bus2.ready = ($urandom_range(0, 99) >= stall_pct);
      if (q.size() == 0) begin
        fin = 1'b1;
        n_vec++;
        if ({bus2.v, busy2, done2, err2, freeze2} !== 6'b001000) begin
          n_err++; $display("FAIL load_done: got v,busy,done,err,freeze=%b expected 001000", {bus2.v, busy2, done2, err2, freeze2});
        end
        n_vec++; if (rom_cfg2 !== sel) begin n_err++; $display("FAIL load_rom_cfg: got %0d expected %0d", rom_cfg2, sel); end
      end else begin
        n_vec++;
        if ({busy2, done2, err2, freeze2} !== {3'b100, exp_freeze}) begin
          n_err++; $display("FAIL load_status c%0d: got %b expected %b", cyc, {busy2, done2, err2, freeze2}, {3'b100, exp_freeze});
        end
        if (cyc == 1) begin
          n_vec++; if (bus2.v !== 1'b0) begin n_err++; $display("FAIL load_fetch_v: got %b expected 0", bus2.v); end
        end
        if (prev_stall) begin
          n_vec++; if (bus2.v !== 1'b1) begin n_err++; $display("FAIL load_hold_v c%0d: got %b expected 1", cyc, bus2.v); end
        end
        if (bus2.v) begin
          got = '{core: bus_core_t'(bus2.core), addr: bus_addr_t'(bus2.addr), data: bus_data_t'(bus2.data)};
          n_vec++;
          if (got !== q[0]) begin
            n_err++; $display("FAIL load_word c%0d: got %h/%h/%h expected %h/%h/%h", cyc, got.core, got.addr, got.data, q[0].core, q[0].addr, q[0].data);
          end
          if (bus2.ready) begin
            if (q[0].addr == 16'h00FF) exp_freeze[q[0].core[0]] = 1'b0;
            void'(q.pop_front());
          end
        end
        prev_stall = bus2.v && !bus2.ready;
      end
      if (mid_start > 0 && cyc == mid_start + 1) begin
        n_vec++; if (rom_cfg2 !== sel) begin n_err++; $display("FAIL mid_start_rom_cfg: got %0d expected %0d", rom_cfg2, sel); end
      end
    end
    if (!fin) begin n_err++; $display("FAIL load_timeout: got %0d words left expected 0", q.size()); end
    start2 = 1'b0;
  endtask

  task automatic test_invalid();
    logic [6:0] bad[3];
    bad[0] = 7'd0; bad[1] = 7'd9; bad[2] = 7'($urandom_range(10, 127));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      start2 = 1'b1; sel2 = bad[i];
      @(negedge clk);
      start2 = 1'b0;
      n_vec++;
      if ({err2, busy2, freeze2} !== 4'b1000) begin
        n_err++; $display("FAIL invalid_%0d: got err,busy,freeze=%b expected 1000", bad[i], {err2, busy2, freeze2});
      end
      repeat (3) begin
        @(negedge clk);
        n_vec++; if (bus2.v !== 1'b0) begin n_err++; $display("FAIL invalid_quiet: got v=%b expected 0", bus2.v); end
      end
    end
  endtask

  task automatic test_reset_mid();
    int hs;
    logic hit;
    hs = 0; hit = 1'b0;
    @(negedge clk);
    start2 = 1'b1; sel2 = 7'd4;
    for (int c = 0; c < 300 && !hit; c++) begin
      @(negedge clk);
      start2 = 1'b0;
      bus2.ready = (hs < 13) ? ($urandom_range(0, 1) == 1) : 1'b0;
      if (bus2.v && bus2.ready) hs++;
      else if (hs == 13 && bus2.v) hit = 1'b1;
    end
    if (!hit) begin n_err++; $display("FAIL reset_mid_timeout: got %0d words expected 13", hs); end
    n_vec++; if (bus2.core !== 1'b1 || bus2.addr !== 8'd5) begin n_err++; $display("FAIL reset_mid_pos: got %b/%h expected 1/05", bus2.core, bus2.addr); end
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({bus2.v, busy2, freeze2} !== 4'b0011) begin
      n_err++; $display("FAIL reset_mid_async: got v,busy,freeze=%b expected 0011", {bus2.v, busy2, freeze2});
    end
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    bus2.ready = 1'b1;
    repeat (6) begin
      @(negedge clk);
      n_vec++;
      if ({bus2.v, busy2, done2, freeze2} !== 5'b00011) begin
        n_err++; $display("FAIL reset_mid_idle: got %b expected 00011", {bus2.v, busy2, done2, freeze2});
      end
    end
  endtask

  initial begin
    start1 = 1'b0; start2 = 1'b0; sel1 = 7'd0; sel2 = 7'd0;
    bus1.ready = 1'b0; bus2.ready = 1'b0;
    test_reset();
    test_single(7'd2, 0, 0);
    test_single(7'd5, 3, 3);
    test_load(7'($urandom_range(1, 8)), 0, 0);
    repeat (3) test_load(7'($urandom_range(1, 8)), 0, 40);
    test_load(7'd4, 2, 30);
    test_invalid();
    test_load(7'd3, 0, 25);
    test_reset_mid();
    test_load(7'd7, 0, 20);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bp_cfg_loader.md
Name: bp_cfg_loader

Overview:
Boot-time configuration sequencer for a parametrised number of cores. On a start pulse it selects one processor configuration by ID and streams that configuration's register words to every core over a valid/ready config bus. It then releases each core from freeze in order. It sits between the configuration ROM (external, combinational lookup) and the per-tile config-bus endpoints. It replaces hard-wired static configuration selection with a runtime-selectable, backpressure-aware load.

Parameters:
num_cores_p, 1, number of cores to configure (cc_x_dim*cc_y_dim of the selected config).
cfg_words_p, 8, config words written per core.
num_cfgs_p, 9, number of valid configuration IDs; ID 0 is the invalid config.
cfg_id_width_p, 7, width of the config ID (lg of max configs).
cfg_addr_width_p, 8, config-bus register address width.
cfg_data_width_p, 64, config-bus data width.
freeze_addr_p, 8'hFF, config-bus address of a core's freeze register.

Ports:
clk_i  in  1  clock
reset_n_i  in  1  asynchronous active-low reset
start_i  in  1  single-cycle start request
cfg_sel_i  in  cfg_id_width_p  requested config ID, sampled with start_i
rom_cfg_o  out  cfg_id_width_p  latched config ID to ROM
rom_addr_o  out  clog2(cfg_words_p)  word index to ROM
rom_data_i  in  cfg_data_width_p  ROM word, combinational from rom_cfg_o/rom_addr_o
cfg_v_o  out  1  config write valid
cfg_ready_i  in  1  config write accepted
cfg_core_o  out  clog2(num_cores_p)  destination core
cfg_addr_o  out  cfg_addr_width_p  register address
cfg_data_o  out  cfg_data_width_p  register data
freeze_o  out  num_cores_p  per-core freeze, 1 = held
busy_o  out  1  load in progress
done_o  out  1  load complete
err_o  out  1  invalid config requested

Behaviour:
- Clock/reset: one clock, clk_i. Reset is asynchronous, active-low, on reset_n_i.
- Reset values (applied immediately on reset_n_i low): cfg_v_o=0, cfg_core_o/addr/data=0, rom_*=0, freeze_o=all 1s, busy_o=0, done_o=0, err_o=0. State goes to IDLE.
- Reset mid-operation aborts the load with no further bus activity. The endpoint sees valid drop asynchronously.
- FSM states: IDLE, FETCH, SEND, UNFREEZE, DONE, ERROR.
- IDLE / DONE / ERROR, on start_i:
  - Latch cfg_sel_i.
  - If cfg_sel_i==0 or cfg_sel_i>=num_cfgs_p: go to ERROR. err_o=1 next cycle; freeze_o is unchanged.
  - Else: clear err_o and done_o, clear core_cnt and word_cnt, set freeze_o to all 1s, go to FETCH.
- start_i in FETCH/SEND/UNFREEZE is ignored.
- FETCH (1 cycle):
  - rom_addr_o=word_cnt.
  - Register rom_data_i into cfg_data_o, word_cnt into cfg_addr_o (zero-extended), core_cnt into cfg_core_o.
  - Go to SEND.
- SEND:
  - cfg_v_o=1; address and data are held stable while cfg_ready_i=0.
  - On handshake:
    - If word_cnt<cfg_words_p-1: increment word_cnt, go to FETCH.
    - Else if core_cnt<num_cores_p-1: word_cnt=0, increment core_cnt, go to FETCH.
    - Else: core_cnt=0, go to UNFREEZE.
- UNFREEZE:
  - cfg_v_o=1, cfg_addr_o=freeze_addr_p, cfg_data_o=0, cfg_core_o=core_cnt.
  - On handshake, clear freeze_o[core_cnt] in the same edge.
  - If last core, go to DONE; else increment core_cnt.
  - No core is unfrozen until every core has been fully written.
- DONE: done_o=1, held until the next accepted start.
- busy_o=1 exactly in FETCH, SEND and UNFREEZE.
- Throughput with cfg_ready_i=1: 2 cycles per word, 1 cycle per unfreeze.
- Counters never wrap. Terminal compares use cfg_words_p-1 and num_cores_p-1. For num_cores_p=1, core-index width is forced to 1.

Decomposition:
- Shared package bp_cfg_loader_pkg:
  - FSM state enum bp_cfg_loader_state_e.
  - Config-bus write struct bp_cfg_bus_s {core, addr, data}.
  - Invalid config ID constant (0).
- Config IDs reuse the existing config enum.
- Sub-module bp_cfg_rom: maps {cfg ID, word index} to a word from the config table. It is instantiated by the parent, not inside this block.

Test Plan:
1. num_cores_p=1, cfg_words_p=8, start at cycle 0 with cfg_sel_i=2, ready=1 -> cfg_v_o high on cycles 2,4,…,16 with addr 0..7 and ROM data; unfreeze write (addr 8'hFF, data 0) on cycle 17; freeze_o 1->0 and done_o=1 at cycle 18.
2. cfg_ready_i low 3 cycles during word 3 SEND -> addr/data/core stable for 4 cycles; total completion delayed by exactly 3 cycles.
3. num_cores_p=2 -> order: core0 words 0..7, core1 words 0..7, unfreeze core0, unfreeze core1; freeze_o goes 2'b11->2'b10->2'b00.
4. start_i with cfg_sel_i=0 and with cfg_sel_i=9 -> err_o=1 next cycle, no cfg_v_o, freeze_o unchanged; a subsequent start with cfg_sel_i=3 clears err_o and loads.
5. start_i pulsed during SEND with a different cfg_sel_i -> ignored; rom_cfg_o keeps the original ID.
6. reset_n_i low mid-SEND (core1 word 5) -> cfg_v_o=0 and freeze_o all 1s before the next edge; after release, IDLE with no bus activity until start.
